// File: rtl/turn_signal_seq.sv
// -----------------------------------------------------------------------------
// turn_signal_seq
//
// Sequential turn-signal controller. Each side has LAMPS lamps that fill from
// the innermost lamp outward, one lamp per sequence step, and then go dark for
// one step. A hazard request, or left and right together, blinks both sides:
// one step fully on, then one step off. A free-running prescaler sets the
// step length to DIV clock cycles.
//
// Ports
//   clk     in   1      clock, rising edge active
//   reset   in   1      asynchronous, active-high reset
//   left    in   1      left turn request (level, synchronous to clk)
//   right   in   1      right turn request (level, synchronous to clk)
//   hazard  in   1      hazard request (level, synchronous to clk)
//   lamp_l  out  LAMPS  left lamps, bit 0 innermost (registered)
//   lamp_r  out  LAMPS  right lamps, bit 0 innermost (registered)
//   busy    out  1      high whenever the sequencer is not idle (registered)
// -----------------------------------------------------------------------------
module turn_signal_seq #(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             busy
);

    // DIV=1 would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP_W = $clog2(LAMPS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ_ON
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [LAMPS-1:0]  lamp_l_q, lamp_l_d;
    logic [LAMPS-1:0]  lamp_r_q, lamp_r_d;
    logic              busy_q,   busy_d;
    logic              tick;

    // Thermometer code with the lowest k bits set.
    function automatic logic [LAMPS-1:0] therm(input logic [STEP_W-1:0] k);
        logic [LAMPS-1:0] t;
        t = '0;
        for (int i = 0; i < LAMPS; i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    // Free-running prescaler; tick marks the last cycle of every step.
    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (hazard || (left && right)) begin
                        state_d = HAZ_ON;
                    end else if (left) begin
                        state_d = LEFT;
                        step_d  = STEP_ONE;
                    end else if (right) begin
                        state_d = RIGHT;
                        step_d  = STEP_ONE;
                    end
                end
                LEFT, RIGHT: begin
                    // Only hazard interrupts a running side sequence; the
                    // request inputs are ignored until IDLE comes back.
                    if (hazard) begin
                        state_d = HAZ_ON;
                    end else if (step_q == STEP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                HAZ_ON: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Lamp decode is taken from the next state so the registered outputs
    // line up with the state register and never see the inputs directly.
    always_comb begin
        lamp_l_d = '0;
        lamp_r_d = '0;
        busy_d   = (state_d != IDLE);
        unique case (state_d)
            LEFT:    lamp_l_d = therm(step_d);
            RIGHT:   lamp_r_d = therm(step_d);
            HAZ_ON: begin
                lamp_l_d = '1;
                lamp_r_d = '1;
            end
            default: begin
                lamp_l_d = '0;
                lamp_r_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            lamp_l_q <= '0;
            lamp_r_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
            busy_q   <= busy_d;
        end
    end

    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_seq
//
// Three instances (LAMPS/DIV = 3/1, 4/4, 8/1) share one clock and one set of
// request inputs. A frame-based reference model predicts the lamp pattern of
// each instance: a side request queues its whole list of thermometer frames,
// hazard replaces whatever is showing with an all-on frame, and an empty
// queue after a lit frame yields one dark frame.
// -----------------------------------------------------------------------------
module tb_turn_signal_seq;

    logic clk = 1'b0;
    logic reset, left, right, hazard;

    logic [2:0] l0, r0;
    logic [3:0] l1, r1;
    logic [7:0] l2, r2;
    logic       b0, b1, b2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_signal_seq #(.LAMPS(3), .DIV(1)) dut0 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l0), .lamp_r(r0), .busy(b0));
    turn_signal_seq #(.LAMPS(4), .DIV(4)) dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l1), .lamp_r(r1), .busy(b1));
    turn_signal_seq #(.LAMPS(8), .DIV(1)) dut2 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l2), .lamp_r(r2), .busy(b2));

    localparam int LM [3] = '{3, 4, 8};
    localparam int DV [3] = '{1, 4, 1};

    // Model: displayed frame {left, right}, pending frames, prescaler phase.
    logic [15:0] frame [3];
    logic [15:0] fq [3][$];
    int          phase [3];

    function automatic logic [7:0] fill(input int k);
        return 8'((1 << k) - 1);
    endfunction

    function automatic logic [15:0] observed(input int d);
        case (d)
            0:       return {5'd0, l0, 5'd0, r0};
            1:       return {4'd0, l1, 4'd0, r1};
            default: return {l2, r2};
        endcase
    endfunction

    function automatic logic observed_busy(input int d);
        case (d)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            frame[d] = '0;
            fq[d].delete();
            phase[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        logic [15:0] cur;
        logic [7:0]  ones;
        logic        side;
        cur  = frame[d];
        ones = fill(LM[d]);
        side = (cur[15:8] != 0) ^ (cur[7:0] != 0);
        if (side && hazard) begin
            fq[d].delete();
            frame[d] = {ones, ones};
        end else if (fq[d].size() > 0) begin
            frame[d] = fq[d].pop_front();
        end else if (cur != 0) begin
            frame[d] = '0;
        end else if (hazard || (left && right)) begin
            frame[d] = {ones, ones};
        end else if (left || right) begin
            for (int k = 1; k <= LM[d]; k++) begin
                fq[d].push_back(left ? {fill(k), 8'h00} : {8'h00, fill(k)});
            end
            frame[d] = fq[d].pop_front();
        end
    endtask

    function automatic logic all_idle();
        for (int d = 0; d < 3; d++) begin
            if (frame[d] != 0 || fq[d].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic compare_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_lamps_d%0d", tag, d), observed(d), frame[d]);
            chk($sformatf("%s_busy_d%0d", tag, d), 16'(observed_busy(d)), 16'(frame[d] != 0));
        end
    endtask

    // One clock: model advances at the rising edge, DUTs are checked at the
    // following falling edge. Returns at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (phase[d] == DV[d] - 1) model_step(d);
                phase[d] = (phase[d] + 1) % DV[d];
            end
        end
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic settle();
        left = 0; right = 0; hazard = 0;
        for (int i = 0; i < 40; i++) begin
            if (all_idle()) break;
            cycle();
        end
        chk("settle_idle", 16'(all_idle()), 16'd1);
    endtask

    initial begin
        logic [2:0] seq028 [5];
        logic [2:0] seq029 [6];
        logic       found;
        int         busy_cnt;
        logic       idle_seen;
        logic       early_right;

        seq028 = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        seq029 = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};

        reset = 1; left = 0; right = 0; hazard = 0;
        model_reset();
        @(negedge clk);
        compare_all("reset");
        cycle();
        cycle();
        reset = 0;

        // Left held on the 3-lamp, DIV=1 instance.
        left = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("left_held_%0d", i), {13'd0, l0}, {13'd0, seq028[i]});
            chk($sformatf("left_held_r_%0d", i), {13'd0, r0}, 16'd0);
        end

        // Hazard raised while the left side shows 011.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame[0] == {8'h00 | 8'h03, 8'h00}) begin found = 1; break; end
            cycle();
        end
        chk("wait_011", 16'(found), 16'd1);
        hazard = 1;
        cycle();
        chk("haz_abort_on", {5'd0, l0, 5'd0, r0}, {8'h07, 8'h07});
        cycle();
        chk("haz_off", {5'd0, l0, 5'd0, r0}, 16'h0000);
        cycle();
        chk("haz_on_again", {5'd0, l0, 5'd0, r0}, {8'h07, 8'h07});
        for (int i = 0; i < 10; i++) cycle();
        settle();

        // Single-cycle right pulse.
        right = 1;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            right = 0;
            if (b0) busy_cnt++;
            chk($sformatf("right_pulse_%0d", i), {13'd0, r0}, {13'd0, seq029[i]});
        end
        chk("right_pulse_busy", 16'(busy_cnt), 16'd3);
        settle();

        // Left and right together: both sides blink on the DIV=4 instance.
        left = 1; right = 1;
        for (int i = 0; i < 40; i++) cycle();
        settle();

        // Reset pulsed between edges while the left side shows 011.
        left = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame[0] == {8'h03, 8'h00}) begin found = 1; break; end
            cycle();
        end
        chk("wait_011_rst", 16'(found), 16'd1);
        #2 reset = 1;
        #1;
        model_reset();
        chk("async_rst_lamps", {5'd0, l0, 5'd0, r0}, 16'h0000);
        chk("async_rst_busy", 16'(b0), 16'd0);
        compare_all("async_rst");
        #1 reset = 0;
        cycle();
        chk("restart_after_rst", {13'd0, l0}, 16'd1);
        for (int i = 0; i < 12; i++) cycle();
        settle();

        // Right held during a LEFT sequence on the 8-lamp instance.
        left = 1;
        cycle();
        left = 0; right = 1;
        idle_seen = 0; early_right = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (l2 == 8'h00 && r2 == 8'h00) idle_seen = 1;
            if (r2 != 8'h00 && !idle_seen) early_right = 1;
        end
        chk("opp_side_idle_gap", 16'(idle_seen), 16'd1);
        chk("opp_side_no_early", 16'(early_right), 16'd0);
        settle();

        // Randomized requests with occasional reset.
        for (int i = 0; i < 600; i++) begin
            left   = ($urandom_range(0, 99) < 35);
            right  = ($urandom_range(0, 99) < 35);
            hazard = ($urandom_range(0, 99) < 10);
            reset  = ($urandom_range(0, 99) < 2);
            cycle();
        end
        reset = 0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/turn_signal_seq.md
TURN_SIGNAL_SEQ -- requirements
Module: turn_signal_seq

Interface
REQ-001 Parameter LAMPS, default 3, SHALL set lamps per side; legal range 2..8.
REQ-002 Parameter DIV, default 1, SHALL set clk cycles per sequence step; legal range 1..2^16.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 left  input  1  SHALL be the left turn request, level-sensitive, synchronous to clk.
REQ-006 right  input  1  SHALL be the right turn request, level-sensitive, synchronous to clk.
REQ-007 hazard  input  1  SHALL be the hazard request, level-sensitive, synchronous to clk.
REQ-008 lamp_l  output  LAMPS  SHALL drive the left lamps; bit 0 is innermost.
REQ-009 lamp_r  output  LAMPS  SHALL drive the right lamps; bit 0 is innermost.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 and wrap, free-running; tick SHALL be high in the cycle where the count equals DIV-1; with DIV=1, tick SHALL be high every cycle.
REQ-012 The FSM SHALL change state only on a rising clk edge that ends a tick cycle, and SHALL sample left, right and hazard only at that edge.
REQ-013 States SHALL be IDLE, LEFT, RIGHT and HAZ_ON; LEFT and RIGHT SHALL carry a step counter of 1..LAMPS.
REQ-014 IDLE transitions SHALL be, in priority order: hazard -> HAZ_ON; left&right -> HAZ_ON; left -> LEFT step 1; right -> RIGHT step 1; none -> stay IDLE.
REQ-015 LEFT/RIGHT at step k<LAMPS SHALL go to step k+1 if hazard=0; at step LAMPS SHALL go to IDLE if hazard=0.
REQ-016 hazard=1 at a tick in LEFT or RIGHT SHALL abort the sequence and go to HAZ_ON.
REQ-017 HAZ_ON SHALL always go to IDLE at the next tick, regardless of inputs, producing an on/off blink of one step each.
REQ-018 Deassertion of left or right mid-sequence SHALL NOT abort the sequence; it SHALL run to step LAMPS and then IDLE.
REQ-019 A request on the opposite side during a LEFT or RIGHT sequence SHALL be ignored until IDLE is re-entered.
REQ-020 Outputs SHALL be registered and SHALL reflect the current state with no combinational path from the inputs.
REQ-021 In IDLE, lamp_l=0 and lamp_r=0.
REQ-022 In LEFT step k, lamp_l SHALL be (2^k)-1, a thermometer filled from bit 0, and lamp_r=0; RIGHT SHALL mirror this on lamp_r with lamp_l=0.
REQ-023 In HAZ_ON, lamp_l and lamp_r SHALL both be all ones.
REQ-024 A held request SHALL repeat with a period of (LAMPS+1)*DIV cycles, including one all-off IDLE step between sequences.
REQ-025 First-lamp latency SHALL be 1..DIV cycles after the request is asserted, depending on the prescaler phase.

Reset
REQ-026 While reset is high, the block SHALL force IDLE, a prescaler count of 0, and lamp_l=0, lamp_r=0, busy=0 immediately, independent of clk.
REQ-027 Reset asserted mid-sequence SHALL clear all outputs without completing the sequence; after release, the prescaler SHALL restart at count 0.

Verification
REQ-028 LAMPS=3, DIV=1, left held -> lamp_l = 001, 011, 111, 000, 001, ...; lamp_r=0 throughout; busy low only in the 000 cycles.
REQ-029 LAMPS=3, DIV=1, right pulsed for one cycle -> lamp_r = 001, 011, 111, then 000 and stays 000; busy high for exactly 3 cycles.
REQ-030 LAMPS=3, DIV=1, left held, hazard raised while lamp_l=011 -> next cycle lamp_l=111 and lamp_r=111, then both 000, then the hazard blink continues while hazard is held.
REQ-031 LAMPS=4, DIV=4, left and right raised together from IDLE -> both sides 1111 for 4 cycles, then 0000 for 4 cycles, repeating.
REQ-032 LAMPS=3, DIV=1, reset pulsed between clock edges while lamp_l=011 -> lamp_l=000 and busy=0 without waiting for a clk edge; a sequence restarts at 001 after release if left is still held.
REQ-033 LAMPS=8, DIV=1, right held during a LEFT sequence -> the LEFT sequence completes to 11111111 and one IDLE step follows; RIGHT does not start before that IDLE step.
